// File: rtl/ibex_bus_responder_if.sv
// Ibex-style req/gnt/rvalid bus bundle between an initiator and a responder.
interface ibex_bus_responder_if;
  logic        req_i;
  logic        gnt_o;
  logic [31:0] addr_i;
  logic        we_i;
  logic [3:0]  be_i;
  logic [31:0] wdata_i;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        err_o;

  modport master (
    output req_i, addr_i, we_i, be_i, wdata_i,
    input  gnt_o, rvalid_o, rdata_o, err_o
  );

  modport slave (
    input  req_i, addr_i, we_i, be_i, wdata_i,
    output gnt_o, rvalid_o, rdata_o, err_o
  );
endinterface

// File: rtl/ibex_bus_responder.sv
// Memory-side responder for the Ibex req/gnt/rvalid bus: word storage,
// fixed-latency in-order responses, outstanding cap, optional grant stalls.
module ibex_bus_responder #(
  parameter int unsigned MemSize        = 4096,
  parameter logic [31:0] BaseAddr       = 32'h0000_0000,
  parameter int unsigned Latency        = 1,
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned GntStallEvery  = 0
) (
  input logic                 clk_i,
  input logic                 rst_ni,
  ibex_bus_responder_if.slave bus
);

  localparam int unsigned Words = MemSize / 4;
  localparam int unsigned IdxW  = (MemSize > 4) ? $clog2(MemSize) - 2 : 1;
  localparam int unsigned OW    = $clog2(MaxOutstanding + 2);
  localparam int unsigned SW    = (GntStallEvery > 0) ? $clog2(GntStallEvery + 1) : 1;

  logic [31:0]          mem [Words];
  logic [32:0]          off;
  logic                 in_range;
  logic [IdxW-1:0]      idx;
  logic                 gnt;
  logic                 accept;
  logic                 stall_cycle;
  logic [SW-1:0]        stall_cnt;
  logic [OW-1:0]        outst;
  logic [Latency:1]     vld_pipe;
  logic [Latency:1]     err_pipe;
  logic [Latency:1][31:0] dat_pipe;
  logic                 rvalid;

  // 33-bit subtraction so addresses below BaseAddr show up as a borrow.
  assign off      = {1'b0, bus.addr_i} - {1'b0, BaseAddr};
  assign in_range = !off[32] && (off[31:0] < MemSize);
  assign idx      = IdxW'(off[31:2]);

  assign stall_cycle = (GntStallEvery != 0) && (stall_cnt == SW'(GntStallEvery));
  // A response leaving this cycle frees its slot immediately, so the grant
  // recovers in the same cycle as the freeing rvalid.
  assign gnt    = bus.req_i && ((outst < OW'(MaxOutstanding)) || rvalid) && !stall_cycle;
  assign accept = bus.req_i && gnt;
  assign rvalid = vld_pipe[Latency];

  assign bus.gnt_o    = gnt;
  assign bus.rvalid_o = rvalid;
  assign bus.err_o    = err_pipe[Latency];
  assign bus.rdata_o  = dat_pipe[Latency];

  // Byte-lane writes into storage; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (accept && in_range && bus.we_i) begin
      for (int k = 0; k < 4; k++) begin
        if (bus.be_i[k]) mem[idx][8*k +: 8] <= bus.wdata_i[8*k +: 8];
      end
    end
  end

  // Response shift register; stage 1 captures the accept-cycle result.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_pipe <= '0;
      err_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      vld_pipe[1] <= accept;
      err_pipe[1] <= accept && !in_range;
      dat_pipe[1] <= (accept && in_range && !bus.we_i) ? mem[idx] : 32'h0;
      for (int k = 2; k <= Latency; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        err_pipe[k] <= err_pipe[k-1];
        dat_pipe[k] <= dat_pipe[k-1];
      end
    end
  end

  // Granted-but-unanswered transaction count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outst <= '0;
    end else begin
      case ({accept, rvalid})
        2'b10:   outst <= outst + OW'(1);
        2'b01:   outst <= outst - OW'(1);
        default: outst <= outst;
      endcase
    end
  end

  // Accept counter; a pending stall waits for the next requesting cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt <= '0;
    end else if (GntStallEvery != 0) begin
      if (stall_cycle && bus.req_i) stall_cnt <= '0;
      else if (accept)              stall_cnt <= stall_cnt + SW'(1);
    end
  end

`ifndef SYNTHESIS
  a_req_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (bus.req_i && !gnt) |=> (bus.req_i && $stable(bus.addr_i) && $stable(bus.we_i)
                             && $stable(bus.be_i) && $stable(bus.wdata_i)));
  a_outst_max: assert property (@(posedge clk_i) disable iff (!rst_ni)
    outst <= OW'(MaxOutstanding));
  a_outst_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(outst == '0 && rvalid));
`endif

endmodule

// File: tb/tb_ibex_bus_responder.sv
// Directed bench: three responder configurations share one clock and reset.
module tb_ibex_bus_responder;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        req [3];
  logic        we [3];
  logic [31:0] addr [3];
  logic [3:0]  be [3];
  logic [31:0] wdata [3];
  logic        gnt [3];
  logic        rvalid [3];
  logic [31:0] rdata [3];
  logic        err [3];

  ibex_bus_responder_if bus0 ();
  ibex_bus_responder_if bus1 ();
  ibex_bus_responder_if bus2 ();

  assign bus0.req_i = req[0]; assign bus0.we_i = we[0]; assign bus0.addr_i = addr[0];
  assign bus0.be_i = be[0]; assign bus0.wdata_i = wdata[0];
  assign gnt[0] = bus0.gnt_o; assign rvalid[0] = bus0.rvalid_o;
  assign rdata[0] = bus0.rdata_o; assign err[0] = bus0.err_o;

  assign bus1.req_i = req[1]; assign bus1.we_i = we[1]; assign bus1.addr_i = addr[1];
  assign bus1.be_i = be[1]; assign bus1.wdata_i = wdata[1];
  assign gnt[1] = bus1.gnt_o; assign rvalid[1] = bus1.rvalid_o;
  assign rdata[1] = bus1.rdata_o; assign err[1] = bus1.err_o;

  assign bus2.req_i = req[2]; assign bus2.we_i = we[2]; assign bus2.addr_i = addr[2];
  assign bus2.be_i = be[2]; assign bus2.wdata_i = wdata[2];
  assign gnt[2] = bus2.gnt_o; assign rvalid[2] = bus2.rvalid_o;
  assign rdata[2] = bus2.rdata_o; assign err[2] = bus2.err_o;

  ibex_bus_responder u_dut0 (.clk_i(clk), .rst_ni(rst_n), .bus(bus0));
  ibex_bus_responder #(.Latency(3), .MaxOutstanding(2)) u_dut1 (.clk_i(clk), .rst_ni(rst_n), .bus(bus1));
  ibex_bus_responder #(.GntStallEvery(2)) u_dut2 (.clk_i(clk), .rst_ni(rst_n), .bus(bus2));

  int n_tests = 0;
  int n_fail  = 0;
  logic        o_gnt, o_rv, o_err;
  logic [31:0] o_rd;

  task chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One bus cycle: drive at negedge, sample combinational gnt and outputs 1ns later.
  task step(input int d, input logic rq, input logic w, input logic [31:0] a,
            input logic [3:0] b, input logic [31:0] wd);
    @(negedge clk);
    req[d] = rq; we[d] = w; addr[d] = a; be[d] = b; wdata[d] = wd;
    #1;
    o_gnt = gnt[d]; o_rv = rvalid[d]; o_rd = rdata[d]; o_err = err[d];
  endtask

  task idle(input int d);
    step(d, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
  endtask

  // Full-word write held until granted, then drained.
  task wr(input int d, input logic [31:0] a, input logic [31:0] wd, input int drain);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 8 && !ok; i++) begin
      step(d, 1'b1, 1'b1, a, 4'hf, wd);
      ok = o_gnt;
    end
    chk($sformatf("wr_gnt_%h", a), ok, 1);
    for (int i = 0; i < drain; i++) idle(d);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] tab4 [4];
    int n, m;
    logic eg, er;
    tab4[0] = 32'hA0A0_0001; tab4[1] = 32'hA0A0_0002;
    tab4[2] = 32'hA0A0_0003; tab4[3] = 32'hA0A0_0004;
    for (int d = 0; d < 3; d++) begin
      req[d] = 0; we[d] = 0; addr[d] = 0; be[d] = 0; wdata[d] = 0;
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_rvalid%0d", d), rvalid[d], 0);
      chk($sformatf("rst_rdata%0d", d), rdata[d], 0);
      chk($sformatf("rst_err%0d", d), err[d], 0);
      chk($sformatf("rst_gnt%0d", d), gnt[d], 0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // 1: write then read, latency 1
    step(0, 1, 1, 32'h10, 4'hf, 32'hDEADBEEF);
    chk("t1_wr_gnt", o_gnt, 1); chk("t1_wr_rv_early", o_rv, 0);
    step(0, 1, 0, 32'h10, 4'hf, 32'h0);
    chk("t1_rd_gnt", o_gnt, 1); chk("t1_wr_rv", o_rv, 1);
    chk("t1_wr_rdata", o_rd, 0); chk("t1_wr_err", o_err, 0);
    idle(0);
    chk("t1_rd_rv", o_rv, 1); chk("t1_rd_rdata", o_rd, 32'hDEADBEEF); chk("t1_rd_err", o_err, 0);
    idle(0);
    chk("t1_rv_pulse", o_rv, 0); chk("t1_rdata_idle", o_rd, 0);

    // 2: partial byte enables
    step(0, 1, 1, 32'h10, 4'hf, 32'hDEADBEEF);
    step(0, 1, 1, 32'h10, 4'b0101, 32'h11223344);
    step(0, 1, 0, 32'h10, 4'hf, 32'h0);
    idle(0);
    chk("t2_be_rv", o_rv, 1); chk("t2_be_rdata", o_rd, 32'hDE22BE44);
    idle(0);

    // 3: range edges and out-of-range accesses
    step(0, 1, 1, 32'h0, 4'hf, 32'hCAFEF00D);
    step(0, 1, 1, 32'hFFC, 4'hf, 32'h12345678);
    step(0, 1, 0, 32'h1000, 4'hf, 32'h0);
    step(0, 1, 1, 32'h2000, 4'hf, 32'hBAD0BAD0);
    chk("t3_oor_rd_rv", o_rv, 1); chk("t3_oor_rd_err", o_err, 1); chk("t3_oor_rd_rdata", o_rd, 0);
    step(0, 1, 0, 32'h0, 4'hf, 32'h0);
    chk("t3_oor_wr_rv", o_rv, 1); chk("t3_oor_wr_err", o_err, 1); chk("t3_oor_wr_rdata", o_rd, 0);
    step(0, 1, 0, 32'hFFC, 4'hf, 32'h0);
    chk("t3_w0_rdata", o_rd, 32'hCAFEF00D); chk("t3_w0_err", o_err, 0);
    idle(0);
    chk("t3_top_rdata", o_rd, 32'h12345678); chk("t3_top_err", o_err, 0);
    idle(0);
    chk("t3_err_idle", o_err, 0);

    // 4: outstanding cap below latency
    for (int i = 0; i < 4; i++) wr(1, 32'h20 + 32'(4*i), tab4[i], 3);
    n = 0; m = 0;
    for (int c = 0; c < 9; c++) begin
      step(1, n < 4, 0, 32'h20 + 32'(4*n), 4'hf, 32'h0);
      eg = (c == 0 || c == 1 || c == 3 || c == 4);
      er = (c == 3 || c == 4 || c == 6 || c == 7);
      chk($sformatf("t4_gnt_c%0d", c), o_gnt, eg);
      chk($sformatf("t4_rv_c%0d", c), o_rv, er);
      if (er) begin
        chk($sformatf("t4_rdata_c%0d", c), o_rd, tab4[m]);
        m++;
      end
      if (o_gnt) n++;
    end

    // 5: grant stall every 2 accepts, stream of writes then reads
    n = 0; m = 0;
    for (int c = 0; c < 19; c++) begin
      step(2, n < 12, n < 6, 32'h40 + 32'(4*(n % 6)), 4'hf, 32'h5A00_0000 + 32'(n));
      eg = (c < 17) && (c % 3 != 2);
      er = (c >= 1) && (c <= 17) && ((c - 1) % 3 != 2);
      chk($sformatf("t5_gnt_c%0d", c), o_gnt, eg);
      chk($sformatf("t5_rv_c%0d", c), o_rv, er);
      if (er) begin
        chk($sformatf("t5_rdata_r%0d", m), o_rd, (m < 6) ? 32'h0 : 32'h5A00_0000 + 32'(m - 6));
        m++;
      end
      if (o_gnt) n++;
    end
    step(2, 1, 0, 32'h40, 4'hf, 32'h0);
    chk("t5_idle_keeps_stall", o_gnt, 0);
    step(2, 1, 0, 32'h40, 4'hf, 32'h0);
    chk("t5_after_stall_gnt", o_gnt, 1);
    idle(2);
    chk("t5_last_rv", o_rv, 1); chk("t5_last_rdata", o_rd, 32'h5A00_0000);

    // 6: reset with a write and a read in flight
    step(1, 1, 1, 32'h30, 4'hf, 32'h77665544);
    chk("t6_wr_gnt", o_gnt, 1);
    step(1, 1, 0, 32'h20, 4'hf, 32'h0);
    chk("t6_rd_gnt", o_gnt, 1);
    @(negedge clk);
    rst_n = 1'b0; req[1] = 1'b0;
    #1;
    chk("t6_rst_rv", rvalid[1], 0);
    repeat (2) @(negedge clk);
    #1;
    chk("t6_rst_rdata", rdata[1], 0); chk("t6_rst_err", err[1], 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      idle(1);
      chk($sformatf("t6_no_rv_c%0d", c), o_rv, 0);
      chk($sformatf("t6_no_rdata_c%0d", c), o_rd, 0);
    end
    step(1, 1, 0, 32'h30, 4'hf, 32'h0);
    chk("t6_post_gnt", o_gnt, 1);
    idle(1); idle(1);
    chk("t6_post_rv_early", o_rv, 0);
    idle(1);
    chk("t6_post_rv", o_rv, 1); chk("t6_post_rdata", o_rd, 32'h77665544);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
